// File: rtl/gpu_shape_pkg.sv
`default_nettype none
// ============================================================================
// Module   : gpu_shape_pkg
// Purpose  : Shared shape-front-end types and helpers: shape codes, the
//            packed vertex type, per-shape segment counts, shape legality
//            and the vertex pair that forms each edge segment.
// Revision : 1.0 - initial release
// ============================================================================
package gpu_shape_pkg;

  localparam int X_W = 10;
  localparam int Y_W = 9;

  // Codes 4..7 are reserved and treated as illegal.
  typedef enum logic [2:0] {
    LINE   = 3'd0,
    TRI    = 3'd1,
    QUAD   = 3'd2,
    CIRCLE = 3'd3
  } shape_t;

  typedef struct packed {
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
  } pos_t;

  // Number of segments a legal shape produces; 0 for reserved codes.
  function automatic logic [2:0] seg_count(input shape_t sh);
    case (sh)
      LINE:    return 3'd1;
      TRI:     return 3'd3;
      QUAD:    return 3'd4;
      CIRCLE:  return 3'd1;
      default: return 3'd0;
    endcase
  endfunction

  // A shape is legal only if the command carries enough vertex slots.
  function automatic logic shape_legal(input shape_t sh, input int max_vert);
    case (sh)
      LINE:    return 1'b1;
      CIRCLE:  return 1'b1;
      TRI:     return (max_vert >= 3);
      QUAD:    return (max_vert >= 4);
      default: return 1'b0;
    endcase
  endfunction

  // Vertex indices {start[1:0], end[1:0]} of segment idx of a shape.
  // The triangle closes with P0->P2 (not P2->P0); the quad wraps P3->P0.
  function automatic logic [3:0] seg_ends(input shape_t sh, input logic [1:0] idx);
    case (sh)
      LINE:    return {2'd0, 2'd1};
      CIRCLE:  return {2'd0, 2'd1};
      TRI: begin
        case (idx)
          2'd0:    return {2'd0, 2'd1};
          2'd1:    return {2'd1, 2'd2};
          default: return {2'd0, 2'd2};
        endcase
      end
      QUAD:    return {idx, idx + 2'd1};
      default: return 4'd0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/segment_sequencer_seg_select.sv
`default_nettype none
// ============================================================================
// Module   : seg_select
// Purpose  : Combinational segment picker. Given the latched vertex bundle,
//            the shape and a segment index, presents the {start,end} pair,
//            whether this is the shape's natural final segment, and whether
//            the pair is a circle {centre,radius}.
// Ports    : pos    - MAX_VERT packed {x,y} vertices, P0 in the MSBs
//            shape  - shape code
//            idx    - segment index within the shape
//            seg    - {start,end}
//            last   - idx is the final segment of the shape
//            circle - seg is centre/radius
// Revision : 1.0 - initial release
// ============================================================================
module seg_select
  import gpu_shape_pkg::*;
#(
  parameter int X_W      = 10,
  parameter int Y_W      = 9,
  parameter int MAX_VERT = 4
) (
  input  logic [MAX_VERT*(X_W+Y_W)-1:0] pos,
  input  shape_t                        shape,
  input  logic [1:0]                    idx,
  output logic [2*(X_W+Y_W)-1:0]        seg,
  output logic                          last,
  output logic                          circle
);

  localparam int POS_W = X_W + Y_W;

  // Unpack into a fixed four-entry table; slots beyond MAX_VERT read as zero
  // and are never selected by a legal shape.
  logic [POS_W-1:0] vert [4];

  for (genvar k = 0; k < 4; k++) begin : g_vert
    if (k < MAX_VERT) begin : g_live
      assign vert[k] = pos[(MAX_VERT-1-k)*POS_W +: POS_W];
    end else begin : g_absent
      assign vert[k] = '0;
    end
  end

  logic [3:0] se;
  logic [2:0] cnt;

  always_comb begin
    se     = seg_ends(shape, idx);
    cnt    = seg_count(shape);
    seg    = {vert[se[3:2]], vert[se[1:0]]};
    last   = (cnt != 3'd0) && ({1'b0, idx} == (cnt - 3'd1));
    circle = (shape == CIRCLE);
  end

endmodule
`default_nettype wire

// File: rtl/segment_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : segment_sequencer
// Purpose  : Accepts one shape command per cmd handshake, latches it, and
//            streams the shape's edge segments one per cycle to the
//            rasteriser with valid/ready backpressure.
// Ports    : clk, n_rst (synchronous, active-low)
//            cmd_valid/cmd_ready/cmd_shape/cmd_pos - command input
//            seg_valid/seg_ready/seg_data/seg_last/seg_circle/seg_idx
//                                                  - segment output stream
//            busy          - a command is latched and still emitting
//            err_bad_shape - one-cycle pulse when an illegal shape is dropped
// Macro    : SEGSEQ_DEGEN_FILTER_EN - skip zero-length segments (start==end);
//            if all segments are degenerate, segment 0 is emitted alone.
//            Circles are never filtered.
// Revision : 1.0 - initial release
// ============================================================================
module segment_sequencer
  import gpu_shape_pkg::*;
#(
  parameter int X_W      = 10,
  parameter int Y_W      = 9,
  parameter int MAX_VERT = 4
) (
  input  logic                          clk,
  input  logic                          n_rst,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  shape_t                        cmd_shape,
  input  logic [MAX_VERT*(X_W+Y_W)-1:0] cmd_pos,
  output logic                          seg_valid,
  input  logic                          seg_ready,
  output logic [2*(X_W+Y_W)-1:0]        seg_data,
  output logic                          seg_last,
  output logic                          seg_circle,
  output logic [1:0]                    seg_idx,
  output logic                          busy,
  output logic                          err_bad_shape
);

  localparam int POS_W = X_W + Y_W;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_EMIT = 1'b1
  } state_t;

  state_t                    state_q, state_d;
  logic [MAX_VERT*POS_W-1:0] pos_q,   pos_d;
  shape_t                    shape_q, shape_d;
  logic [1:0]                idx_q,   idx_d;
  logic                      err_q,   err_d;

  logic                      legal;
  logic                      accept;
  logic [2*POS_W-1:0]        sel_seg;
  logic                      sel_last;
  logic                      sel_circle;
  logic                      last;
  logic [1:0]                first_idx;
  logic [1:0]                next_idx;

  assign legal  = shape_legal(cmd_shape, MAX_VERT);
  assign accept = (state_q == S_IDLE) && cmd_valid && legal;

  seg_select #(
    .X_W      (X_W),
    .Y_W      (Y_W),
    .MAX_VERT (MAX_VERT)
  ) u_seg_select (
    .pos    (pos_q),
    .shape  (shape_q),
    .idx    (idx_q),
    .seg    (sel_seg),
    .last   (sel_last),
    .circle (sel_circle)
  );

`ifdef SEGSEQ_DEGEN_FILTER_EN
  logic [3:0] mask_q, mask_d;
  logic [3:0] mask_in;
  logic       more;

  function automatic logic [POS_W-1:0] vert_of(
    input logic [MAX_VERT*POS_W-1:0] p,
    input logic [1:0]                k
  );
    logic [MAX_VERT*POS_W-1:0] sh;
    if (int'(k) >= MAX_VERT) return '0;
    sh = p >> (POS_W * (MAX_VERT - 1 - int'(k)));
    return sh[POS_W-1:0];
  endfunction

  // Mask of non-degenerate segments, taken from the incoming command so it
  // is ready alongside the latch.
  always_comb begin
    logic [3:0] se;
    logic [2:0] cnt;
    mask_in   = 4'd0;
    first_idx = 2'd0;
    cnt       = seg_count(cmd_shape);
    for (int i = 0; i < 4; i++) begin
      se = seg_ends(cmd_shape, 2'(i));
      if ((i < int'(cnt)) &&
          (vert_of(cmd_pos, se[3:2]) != vert_of(cmd_pos, se[1:0]))) begin
        mask_in[i] = 1'b1;
      end
    end
    // Circles are never filtered; an all-degenerate shape becomes a point draw.
    if ((cmd_shape == CIRCLE) || (mask_in == 4'd0)) begin
      mask_in = 4'b0001;
    end
    for (int i = 3; i >= 0; i--) begin
      if (mask_in[i]) first_idx = 2'(i);
    end
  end

  // Lowest surviving segment above the current one, if any.
  always_comb begin
    next_idx = idx_q;
    more     = 1'b0;
    for (int i = 3; i >= 0; i--) begin
      if ((i > int'(idx_q)) && mask_q[i]) begin
        next_idx = 2'(i);
        more     = 1'b1;
      end
    end
  end

  // The natural final segment can never have a survivor above it, so OR-ing
  // keeps both views consistent.
  assign last   = sel_last | ~more;
  assign mask_d = accept ? mask_in : mask_q;

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      mask_q <= 4'd0;
    end else begin
      mask_q <= mask_d;
    end
  end
`else
  assign first_idx = 2'd0;
  assign next_idx  = idx_q + 2'd1;
  assign last      = sel_last;
`endif

  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    shape_d = shape_q;
    idx_d   = idx_q;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          if (legal) begin
            pos_d   = cmd_pos;
            shape_d = cmd_shape;
            idx_d   = first_idx;
            state_d = S_EMIT;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_EMIT: begin
        if (seg_ready) begin
          if (last) begin
            idx_d   = 2'd0;
            state_d = S_IDLE;
          end else begin
            idx_d = next_idx;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q <= S_IDLE;
      pos_q   <= '0;
      shape_q <= LINE;
      idx_q   <= 2'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      shape_q <= shape_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
    end
  end

  // seg_valid is the registered EMIT state; payload is zeroed while idle so
  // stale coordinates never appear on the bus.
  assign cmd_ready     = (state_q == S_IDLE);
  assign busy          = (state_q == S_EMIT);
  assign seg_valid     = (state_q == S_EMIT);
  assign seg_data      = seg_valid ? sel_seg : '0;
  assign seg_last      = seg_valid & last;
  assign seg_circle    = seg_valid & sel_circle;
  assign seg_idx       = idx_q;
  assign err_bad_shape = err_q;

endmodule
`default_nettype wire

// File: tb/tb_segment_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_segment_sequencer
// Purpose  : Table-driven self-checking bench for segment_sequencer, plus
//            hand-written sequences for reset mid-command and command
//            backpressure while emitting.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_segment_sequencer;
  import gpu_shape_pkg::*;

  localparam int XW = 10;
  localparam int YW = 9;
  localparam int MV = 4;
  localparam int PW = XW + YW;

  logic           clk       = 1'b0;
  logic           n_rst     = 1'b0;
  logic           cmd_valid = 1'b0;
  logic           seg_ready = 1'b0;
  shape_t         cmd_shape = LINE;
  logic [MV*PW-1:0] cmd_pos = '0;
  logic           cmd_ready, seg_valid, seg_last, seg_circle, busy, err_bad_shape;
  logic [2*PW-1:0] seg_data;
  logic [1:0]     seg_idx;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  segment_sequencer #(
    .X_W      (XW),
    .Y_W      (YW),
    .MAX_VERT (MV)
  ) dut (
    .clk           (clk),
    .n_rst         (n_rst),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_shape     (cmd_shape),
    .cmd_pos       (cmd_pos),
    .seg_valid     (seg_valid),
    .seg_ready     (seg_ready),
    .seg_data      (seg_data),
    .seg_last      (seg_last),
    .seg_circle    (seg_circle),
    .seg_idx       (seg_idx),
    .busy          (busy),
    .err_bad_shape (err_bad_shape)
  );

  typedef struct {
    shape_t                shape;
    logic [MV*PW-1:0]      pos;
    bit                    toggle;
    bit                    bad;
    bit                    circ;
    int                    nb;
    logic [3:0][2*PW-1:0]  data;
    logic [3:0][1:0]       idx;
  } vec_t;

  vec_t vt[9];

  function automatic logic [PW-1:0] pt(input int x, input int y);
    logic [XW-1:0] xx;
    logic [YW-1:0] yy;
    xx = XW'(x);
    yy = YW'(y);
    return {xx, yy};
  endfunction

  function automatic vec_t mk(input shape_t s, input logic [PW-1:0] p0, input logic [PW-1:0] p1,
                              input logic [PW-1:0] p2, input logic [PW-1:0] p3,
                              input bit tog, input bit bad);
    vec_t v;
    v.shape  = s;
    v.pos    = {p0, p1, p2, p3};
    v.toggle = tog;
    v.bad    = bad;
    v.circ   = 1'b0;
    v.nb     = 0;
    v.data   = '0;
    v.idx    = '0;
    return v;
  endfunction

  function automatic vec_t beat(input vec_t v, input logic [2*PW-1:0] d, input logic [1:0] i);
    vec_t r;
    r = v;
    r.data[r.nb] = d;
    r.idx[r.nb]  = i;
    r.nb++;
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic run(input vec_t v, input string nm);
    int bt;
    int cyc;
    bt  = 0;
    cyc = 0;
    chk({nm, " cmd_ready before"}, 64'(cmd_ready), 64'(1));
    cmd_valid = 1'b1;
    cmd_shape = v.shape;
    cmd_pos   = v.pos;
    seg_ready = 1'b0;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    if (v.bad) begin
      chk({nm, " err pulse"},       64'(err_bad_shape), 64'(1));
      chk({nm, " err seg_valid"},   64'(seg_valid),     64'(0));
      chk({nm, " err cmd_ready"},   64'(cmd_ready),     64'(1));
      @(posedge clk); #1;
      chk({nm, " err one cycle"},   64'(err_bad_shape), 64'(0));
      chk({nm, " err no segment"},  64'(seg_valid),     64'(0));
    end else begin
      chk({nm, " busy"},      64'(busy),          64'(1));
      chk({nm, " cmd_ready"}, 64'(cmd_ready),     64'(0));
      chk({nm, " no err"},    64'(err_bad_shape), 64'(0));
      while (bt < v.nb && cyc < 40) begin
        seg_ready = v.toggle ? cyc[0] : 1'b1;
        chk($sformatf("%s b%0d valid", nm, bt),  64'(seg_valid),  64'(1));
        chk($sformatf("%s b%0d data", nm, bt),   64'(seg_data),   64'(v.data[bt]));
        chk($sformatf("%s b%0d idx", nm, bt),    64'(seg_idx),    64'(v.idx[bt]));
        chk($sformatf("%s b%0d last", nm, bt),   64'(seg_last),   64'(bt == v.nb - 1));
        chk($sformatf("%s b%0d circle", nm, bt), 64'(seg_circle), 64'(v.circ));
        @(posedge clk); #1;
        if (seg_ready) bt++;
        cyc++;
      end
      seg_ready = 1'b0;
      if (bt < v.nb) begin
        checks++;
        errors++;
        $display("FAIL %s timeout beats=%0d required=%0d", nm, bt, v.nb);
      end
      chk({nm, " done seg_valid"}, 64'(seg_valid), 64'(0));
      chk({nm, " done cmd_ready"}, 64'(cmd_ready), 64'(1));
      chk({nm, " done busy"},      64'(busy),      64'(0));
    end
  endtask

  initial begin
    logic [PW-1:0] a, b, c, d, e, f, g, z;
    z = '0;

    // LINE
    a = pt(10, 20); b = pt(100, 200);
    vt[0] = mk(LINE, a, b, z, z, 1'b0, 1'b0);
    vt[0] = beat(vt[0], {a, b}, 2'd0);
    // TRI with stalls
    a = pt(0, 0); b = pt(5, 0); c = pt(0, 5);
    vt[1] = mk(TRI, a, b, c, z, 1'b1, 1'b0);
    vt[1] = beat(vt[1], {a, b}, 2'd0);
    vt[1] = beat(vt[1], {b, c}, 2'd1);
    vt[1] = beat(vt[1], {a, c}, 2'd2);
    // QUAD rectangle
    a = pt(1, 1); b = pt(8, 1); c = pt(8, 4); d = pt(1, 4);
    vt[2] = mk(QUAD, a, b, c, d, 1'b0, 1'b0);
    vt[2] = beat(vt[2], {a, b}, 2'd0);
    vt[2] = beat(vt[2], {b, c}, 2'd1);
    vt[2] = beat(vt[2], {c, d}, 2'd2);
    vt[2] = beat(vt[2], {d, a}, 2'd3);
    // CIRCLE
    a = pt(320, 240); b = pt(50, 0);
    vt[3] = mk(CIRCLE, a, b, z, z, 1'b0, 1'b0);
    vt[3].circ = 1'b1;
    vt[3] = beat(vt[3], {a, b}, 2'd0);
    // reserved shape 6
    vt[4] = mk(shape_t'(3'd6), pt(1, 2), pt(3, 4), z, z, 1'b0, 1'b1);
    // TRI with P0==P1
    e = pt(3, 3); f = pt(9, 9);
    vt[5] = mk(TRI, e, e, f, z, 1'b0, 1'b0);
`ifdef SEGSEQ_DEGEN_FILTER_EN
    vt[5] = beat(vt[5], {e, f}, 2'd1);
    vt[5] = beat(vt[5], {e, f}, 2'd2);
`else
    vt[5] = beat(vt[5], {e, e}, 2'd0);
    vt[5] = beat(vt[5], {e, f}, 2'd1);
    vt[5] = beat(vt[5], {e, f}, 2'd2);
`endif
    // fully degenerate QUAD
    g = pt(2, 2);
    vt[6] = mk(QUAD, g, g, g, g, 1'b1, 1'b0);
`ifdef SEGSEQ_DEGEN_FILTER_EN
    vt[6] = beat(vt[6], {g, g}, 2'd0);
`else
    for (int i = 0; i < 4; i++) vt[6] = beat(vt[6], {g, g}, 2'(i));
`endif
    // reserved shape 4
    vt[7] = mk(shape_t'(3'd4), pt(7, 7), pt(8, 8), z, z, 1'b0, 1'b1);
    // LINE with stalls; unused slots hold junk that must not leak
    a = pt(1023, 511); b = pt(0, 1);
    vt[8] = mk(LINE, a, b, pt(77, 66), pt(55, 44), 1'b1, 1'b0);
    vt[8] = beat(vt[8], {a, b}, 2'd0);

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset cmd_ready",  64'(cmd_ready),     64'(1));
    chk("reset seg_valid",  64'(seg_valid),     64'(0));
    chk("reset seg_data",   64'(seg_data),      64'(0));
    chk("reset seg_last",   64'(seg_last),      64'(0));
    chk("reset seg_circle", 64'(seg_circle),    64'(0));
    chk("reset seg_idx",    64'(seg_idx),       64'(0));
    chk("reset busy",       64'(busy),          64'(0));
    chk("reset err",        64'(err_bad_shape), 64'(0));
    n_rst = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 9; i++) begin
      run(vt[i], $sformatf("vec%0d", i));
    end

    // Reset in the middle of a triangle, after beat 0 is taken
    cmd_valid = 1'b1; cmd_shape = TRI; cmd_pos = vt[1].pos;
    @(posedge clk); #1;
    cmd_valid = 1'b0; seg_ready = 1'b1;
    @(posedge clk); #1;
    seg_ready = 1'b0;
    chk("midrst before idx",   64'(seg_idx),   64'(1));
    chk("midrst before valid", 64'(seg_valid), 64'(1));
    n_rst = 1'b0;
    @(posedge clk); #1;
    n_rst = 1'b1;
    chk("midrst seg_valid", 64'(seg_valid), 64'(0));
    chk("midrst busy",      64'(busy),      64'(0));
    chk("midrst cmd_ready", 64'(cmd_ready), 64'(1));
    chk("midrst seg_data",  64'(seg_data),  64'(0));
    chk("midrst seg_idx",   64'(seg_idx),   64'(0));
    @(posedge clk); #1;
    chk("midrst stays idle", 64'(seg_valid), 64'(0));

    // cmd_valid held during EMIT is ignored; picked up after the bubble
    cmd_valid = 1'b1; cmd_shape = LINE; cmd_pos = vt[0].pos;
    @(posedge clk); #1;
    cmd_shape = QUAD; cmd_pos = vt[2].pos;
    for (int i = 0; i < 3; i++) begin
      chk("hold cmd_ready", 64'(cmd_ready), 64'(0));
      chk("hold data",      64'(seg_data),  64'(vt[0].data[0]));
      chk("hold idx",       64'(seg_idx),   64'(0));
      @(posedge clk); #1;
    end
    seg_ready = 1'b1;
    @(posedge clk); #1;
    seg_ready = 1'b0;
    chk("bubble seg_valid", 64'(seg_valid), 64'(0));
    chk("bubble cmd_ready", 64'(cmd_ready), 64'(1));
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    chk("second valid", 64'(seg_valid), 64'(1));
    chk("second data",  64'(seg_data),  64'(vt[2].data[0]));
    chk("second last",  64'(seg_last),  64'(0));
    seg_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    seg_ready = 1'b0;
    chk("second drained", 64'(cmd_ready), 64'(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/segment_sequencer.md
Name: segment_sequencer

Overview:
- Successor to the combinational location splitter in the shape front-end.
- Accepts one shape command (shape code plus packed vertex positions) per valid/ready handshake.
- Emits that shape's edge segments one per cycle as {start,end} pairs over a valid/ready stream to the rasteriser (line/circle engines).
- Parametrised in coordinate width and vertex count; adds quadrilaterals and backpressure.

Parameters:
- X_W, 10, x coordinate bits.
- Y_W, 9, y coordinate bits; POS_W = X_W+Y_W (derived localparam).
- MAX_VERT, 4, vertex slots in cmd_pos; legal range 2..4.

Ports:
- clk  in  1  system clock
- n_rst  in  1  reset, synchronous, active-low
- cmd_valid  in  1  command present
- cmd_ready  out  1  block can accept a command
- cmd_shape  in  3  shape code (gpu_shape_pkg::shape_t)
- cmd_pos  in  MAX_VERT*POS_W  vertices; P0 in the MSBs; each vertex is {x,y}
- seg_valid  out  1  segment present
- seg_ready  in  1  downstream accepts
- seg_data  out  2*POS_W  {start,end}; for circle, {centre,radius}
- seg_last  out  1  final segment of the current command
- seg_circle  out  1  seg_data is centre/radius, not an edge
- seg_idx  out  2  index of the segment within its command
- busy  out  1  command latched, not yet fully emitted
- err_bad_shape  out  1  one-cycle pulse when an illegal shape is dropped

Behaviour:
- Reset (n_rst=0 at a clk edge):
  - State goes to IDLE.
  - Outputs: cmd_ready=1, seg_valid=0, seg_data=0, seg_last=0, seg_circle=0, seg_idx=0, busy=0, err_bad_shape=0.
  - Reset mid-command discards the command; no partial output.
- States IDLE and EMIT. cmd_ready = (state==IDLE). busy = (state==EMIT).
- IDLE, on cmd_valid and legal shape:
  - Latch cmd_shape and cmd_pos; set seg_idx=0.
  - Go to EMIT. seg_valid is registered and first asserts the cycle after acceptance (latency 1).
- IDLE, on cmd_valid and illegal shape:
  - Illegal means a reserved code, or QUAD with MAX_VERT<4, or TRI with MAX_VERT<3.
  - Command is consumed; err_bad_shape pulses 1 cycle; stay in IDLE; no segment emitted.
- Segment lists, in emission order:
  - LINE: P0->P1 (1 segment).
  - TRI: P0->P1, P1->P2, P0->P2 (3 segments).
  - QUAD: P0->P1, P1->P2, P2->P3, P3->P0 (4 segments).
  - CIRCLE: {P0,P1}, with seg_circle=1 (1 segment).
- EMIT handshake:
  - seg_data, seg_last, seg_circle and seg_idx stay stable while seg_valid=1 and seg_ready=0.
  - On seg_valid&&seg_ready with seg_last=0: seg_idx increments and the next segment is presented the following cycle.
  - On seg_valid&&seg_ready with seg_last=1: go to IDLE, seg_valid=0 next cycle, cmd_ready=1 next cycle. There is one bubble cycle between commands.
- seg_ready is ignored while seg_valid=0.
- cmd_valid is ignored in EMIT; the command is held upstream.
- Coordinates pass through unmodified; no arithmetic and no clipping.

Optional Feature:
- Macro: SEGSEQ_DEGEN_FILTER_EN.
- With the macro defined:
  - At acceptance, compute a mask of non-degenerate segments (start!=end). Only masked segments are emitted; seg_idx still reports the original index; seg_last marks the last emitted segment.
  - If every segment is degenerate, segment 0 alone is emitted (point draw) with seg_last=1.
  - CIRCLE is never filtered.
- Without the macro: every segment is emitted unconditionally.

Decomposition:
- Package gpu_shape_pkg:
  - shape_t enum: LINE=3'd0, TRI=3'd1, QUAD=3'd2, CIRCLE=3'd3; codes 4..7 reserved.
  - Function seg_count(shape_t).
  - pos_t packed struct {x,y}, parametrised through the package localparams X_W/Y_W.
- One sub-module, seg_select (combinational):
  - Inputs: latched cmd_pos, shape, seg_idx.
  - Outputs: {start,end}, last, circle.
- segment_sequencer holds the FSM, the latch, the index counter and the optional filter.

Test Plan:
- Test plan values use P(x,y) with default widths.
- LINE, P0=(10,20), P1=(100,200), seg_ready=1 → one beat, seg_data={(10,20),(100,200)}, seg_last=1, seg_idx=0, cmd_ready high again 2 cycles after acceptance.
- TRI, P0=(0,0), P1=(5,0), P2=(0,5), seg_ready toggling 1/0 → three beats in order (0,0)->(5,0), (5,0)->(0,5), (0,0)->(0,5); data stable during stalls; seg_last only on beat 2.
- QUAD with rectangle corners (1,1),(8,1),(8,4),(1,4) → 4 beats, final beat (1,4)->(1,1) with seg_last=1.
- CIRCLE centre (320,240), radius field (50,0) → one beat, seg_circle=1, seg_data={(320,240),(50,0)}.
- cmd_shape=3'd6 → err_bad_shape pulses 1 cycle, seg_valid stays 0, cmd_ready stays 1.
- n_rst=0 mid-TRI after beat 0 → next cycle seg_valid=0, busy=0, cmd_ready=1. With SEGSEQ_DEGEN_FILTER_EN and TRI P1=P0=(3,3), P2=(9,9) → only beats 1 and 2 are emitted (idx 1, 2).
